// File: rtl/decode_pkg.sv
// Shared definitions for the RV32 decode stage: opcodes, funct7 constants,
// control encodings, the control bundle type and operand-use helpers.
package decode_pkg;

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // R-type funct7 values: base ALU ops, SUB/SRA, and the M extension.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_JAL  = 2'b01,
    JUMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [1:0] {
    UPPER_NONE  = 2'b00,
    UPPER_LUI   = 2'b01,
    UPPER_AUIPC = 2'b10
  } upper_e;

  typedef struct packed {
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
    jump_e   jump;
    upper_e  upper_imm;
  } ctrl_t;

  // Instruction formats that actually read rs1 / rs2; only these can
  // depend on an in-flight load.
  function automatic logic reads_rs1(input logic [6:0] opcode);
    return opcode inside {OPC_RTYPE, OPC_IALU, OPC_LOAD, OPC_STORE,
                          OPC_BRANCH, OPC_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opcode);
    return opcode inside {OPC_RTYPE, OPC_STORE, OPC_BRANCH};
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational main decoder: opcode/funct7 -> control bundle + illegal flag.
// Ports:
//   opcode  in  7   instruction[6:0]
//   funct7  in  7   instruction[31:25]
//   ctrl    out     control bundle (all zero when illegal)
//   illegal out 1   unsupported opcode or R-type funct7
module decode_ctrl
  import decode_pkg::*;
#(
  parameter bit EN_MEXT = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal
);

  logic funct7_ok;

  assign funct7_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT) ||
                     (EN_MEXT && (funct7 == F7_MEXT));

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave a bit unassigned and infer a latch.
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
        illegal        = ~funct7_ok;
      end
      OPC_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OPC_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_BRANCH;
      end
      OPC_IALU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ITYPE;
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ITYPE;
        ctrl.jump      = JUMP_JAL;
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ITYPE;
        ctrl.jump      = JUMP_JALR;
      end
      OPC_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.upper_imm = UPPER_LUI;
      end
      OPC_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.upper_imm = UPPER_AUIPC;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal bundles travel downstream inert.
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between IF/ID and ID/EX. Accepts one instruction
// per cycle (valid/ready), presents the decoded bundle one cycle later, and
// inserts a single bubble when an instruction needs the result of a load
// that has just left this stage.
// Ports:
//   clk_i, rst_i (async, active-low)
//   in_valid_i/in_ready_o, instr_i, pc_i        upstream handshake + payload
//   flush_i                                      kill bundle and interlock
//   out_valid_o/out_ready_i                      downstream handshake
//   out_pc_o, out_instr_o                        registered PC / instruction
//   ALUSrc_o..Branch_o, ALUOp_o, Jump_o,
//   UpperImm_o, rs1_o, rs2_o, rd_o, illegal_o    registered control bundle
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_MEXT   = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_instr_o,
  output logic            ALUSrc_o,
  output logic            MemtoReg_o,
  output logic            RegWrite_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            Branch_o,
  output logic [1:0]      ALUOp_o,
  output logic [1:0]      Jump_o,
  output logic [1:0]      UpperImm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o
);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;

  logic            out_valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  ctrl_t           ctrl_q;
  logic            illegal_q;

  logic            ld_pend_q;
  logic [4:0]      ld_rd_q;

  logic            dependency;
  logic            stall;
  logic            accept;
  logic            transfer;
  logic            ld_set;
  logic            ld_clear;

  decode_ctrl #(
    .EN_MEXT (EN_MEXT)
  ) u_ctrl (
    .opcode  (instr_i[6:0]),
    .funct7  (instr_i[31:25]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Incoming instruction reads the register the last load is still filling.
  assign dependency = (reads_rs1(instr_i[6:0]) && (instr_i[19:15] == ld_rd_q)) ||
                      (reads_rs2(instr_i[6:0]) && (instr_i[24:20] == ld_rd_q));
  assign stall      = HAZARD_EN && ld_pend_q && in_valid_i && dependency;

  assign in_ready_o = (~out_valid_q | out_ready_i) & ~flush_i & ~stall;
  assign accept     = in_valid_i & in_ready_o;
  assign transfer   = out_valid_q & out_ready_i;

  // x0 loads never create a hazard.
  assign ld_set     = HAZARD_EN && transfer && ctrl_q.mem_read &&
                      (instr_q[11:7] != 5'd0);
  // Pending load has advanced one more slot once downstream moves again.
  assign ld_clear   = ld_pend_q & out_ready_i;

  // Output register. Data only loads on accept, which already excludes flush
  // and backpressure, so the bundle holds while stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_i) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      instr_q     <= '0;
      ctrl_q      <= '0;
      illegal_q   <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= pc_i;
      instr_q     <= instr_i;
      ctrl_q      <= dec_ctrl;
      illegal_q   <= dec_illegal;
    end else if (transfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // Load-use interlock; a new load leaving wins over the clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ld_pend_q <= 1'b0;
      ld_rd_q   <= 5'd0;
    end else if (flush_i) begin
      ld_pend_q <= 1'b0;
    end else if (ld_set) begin
      ld_pend_q <= 1'b1;
      ld_rd_q   <= instr_q[11:7];
    end else if (ld_clear) begin
      ld_pend_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pc_o    = pc_q;
  assign out_instr_o = instr_q;
  assign ALUSrc_o    = ctrl_q.alu_src;
  assign MemtoReg_o  = ctrl_q.mem_to_reg;
  assign RegWrite_o  = ctrl_q.reg_write;
  assign MemRead_o   = ctrl_q.mem_read;
  assign MemWrite_o  = ctrl_q.mem_write;
  assign Branch_o    = ctrl_q.branch;
  assign ALUOp_o     = ctrl_q.alu_op;
  assign Jump_o      = ctrl_q.jump;
  assign UpperImm_o  = ctrl_q.upper_imm;
  assign rs1_o       = instr_q[19:15];
  assign rs2_o       = instr_q[24:20];
  assign rd_o        = instr_q[11:7];
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
// A second instance with EN_MEXT=0 shares the inputs.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int BW   = XLEN + 32 + 12 + 15 + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic [31:0]     instr_i = '0;
  logic [XLEN-1:0] pc_i = '0;
  logic            flush_i = 1'b0;
  logic            out_ready_i = 1'b0;

  logic            in_ready_o, out_valid_o;
  logic [XLEN-1:0] out_pc_o;
  logic [31:0]     out_instr_o;
  logic            ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o;
  logic [1:0]      ALUOp_o, Jump_o, UpperImm_o;
  logic [4:0]      rs1_o, rs2_o, rd_o;
  logic            illegal_o;

  logic            n_in_ready, n_out_valid;
  logic [XLEN-1:0] n_out_pc;
  logic [31:0]     n_out_instr;
  logic            n_alu_src, n_mem_to_reg, n_reg_write, n_mem_read, n_mem_write, n_branch;
  logic [1:0]      n_alu_op, n_jump, n_upper;
  logic [4:0]      n_rs1, n_rs2, n_rd;
  logic            n_illegal;

  always #5 clk_i = ~clk_i;

  decode_stage #(.XLEN(XLEN), .EN_MEXT(1'b1), .HAZARD_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
    .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
    .ALUOp_o(ALUOp_o), .Jump_o(Jump_o), .UpperImm_o(UpperImm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .illegal_o(illegal_o)
  );

  decode_stage #(.XLEN(XLEN), .EN_MEXT(1'b0), .HAZARD_EN(1'b1)) dut_nom (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(n_in_ready),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(n_out_valid),
    .out_ready_i(out_ready_i), .out_pc_o(n_out_pc), .out_instr_o(n_out_instr),
    .ALUSrc_o(n_alu_src), .MemtoReg_o(n_mem_to_reg), .RegWrite_o(n_reg_write),
    .MemRead_o(n_mem_read), .MemWrite_o(n_mem_write), .Branch_o(n_branch),
    .ALUOp_o(n_alu_op), .Jump_o(n_jump), .UpperImm_o(n_upper),
    .rs1_o(n_rs1), .rs2_o(n_rs2), .rd_o(n_rd), .illegal_o(n_illegal)
  );

  logic [BW-1:0] obs, obs_n;
  logic [11:0]   obs_ctrl;
  assign obs_ctrl = {ALUSrc_o, MemtoReg_o, RegWrite_o, MemRead_o, MemWrite_o,
                     Branch_o, ALUOp_o, Jump_o, UpperImm_o};
  assign obs   = {out_pc_o, out_instr_o, obs_ctrl, rs1_o, rs2_o, rd_o, illegal_o};
  assign obs_n = {n_out_pc, n_out_instr, n_alu_src, n_mem_to_reg, n_reg_write,
                  n_mem_read, n_mem_write, n_branch, n_alu_op, n_jump, n_upper,
                  n_rs1, n_rs2, n_rd, n_illegal};

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic          m_valid, m_pend, m_load;
  logic [4:0]    m_ld_rd, m_rd;
  logic [BW-1:0] m_bundle, m_bundle_n;

  // Decode table written out row by row:
  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Jump,UpperImm}
  function automatic logic [BW-1:0] ref_bundle(input logic [31:0] pc, input logic [31:0] ins,
                                               input bit mext);
    logic [11:0] c;
    bit          ill;
    logic [6:0]  f7;
    f7  = ins[31:25];
    ill = 1'b0;
    c   = '0;
    case (ins[6:0])
      7'b0110011: begin
        c = 12'b001000_10_00_00;
        if (!(f7 == 7'h00 || f7 == 7'h20 || (mext && f7 == 7'h01))) ill = 1'b1;
      end
      7'b0000011: c = 12'b111100_00_00_00;
      7'b0100011: c = 12'b100010_00_00_00;
      7'b1100011: c = 12'b000001_01_00_00;
      7'b0010011: c = 12'b101000_11_00_00;
      7'b1101111: c = 12'b001000_11_01_00;
      7'b1100111: c = 12'b001000_11_10_00;
      7'b0110111: c = 12'b101000_00_00_01;
      7'b0010111: c = 12'b101000_00_00_10;
      default:    ill = 1'b1;
    endcase
    if (ill) c = '0;
    return {pc, ins, c, ins[19:15], ins[24:20], ins[11:7], ill};
  endfunction

  task automatic model_reset();
    m_valid    = 1'b0;
    m_pend     = 1'b0;
    m_load     = 1'b0;
    m_ld_rd    = 5'd0;
    m_rd       = 5'd0;
    m_bundle   = '0;
    m_bundle_n = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1
  // time unit after the rising edge with outputs settled.
  task automatic tick();
    logic [6:0] op;
    logic       dep, stall, rdy, acc, xfer;
    @(negedge clk_i);
    op    = instr_i[6:0];
    dep   = ((op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111})
             && instr_i[19:15] == m_ld_rd) ||
            ((op inside {7'b0110011, 7'b0100011, 7'b1100011}) && instr_i[24:20] == m_ld_rd);
    stall = m_pend && in_valid_i && dep;
    rdy   = (!m_valid || out_ready_i) && !flush_i && !stall;
    check("in_ready",       BW'(in_ready_o),  BW'(rdy));
    check("in_ready_nom",   BW'(n_in_ready),  BW'(rdy));
    check("out_valid",      BW'(out_valid_o), BW'(m_valid));
    check("out_valid_nom",  BW'(n_out_valid), BW'(m_valid));
    check("bundle",         obs,              m_bundle);
    check("bundle_nom",     obs_n,            m_bundle_n);
    acc  = in_valid_i && rdy;
    xfer = m_valid && out_ready_i;
    if (flush_i) begin
      m_valid = 1'b0;
      m_pend  = 1'b0;
    end else begin
      if (xfer && m_load && m_rd != 5'd0) begin
        m_pend  = 1'b1;
        m_ld_rd = m_rd;
      end else if (m_pend && out_ready_i) begin
        m_pend = 1'b0;
      end
      if (acc) begin
        m_valid    = 1'b1;
        m_bundle   = ref_bundle(pc_i, instr_i, 1'b1);
        m_bundle_n = ref_bundle(pc_i, instr_i, 1'b0);
        m_load     = (instr_i[6:0] == 7'b0000011);
        m_rd       = instr_i[11:7];
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    in_valid_i  = v;
    instr_i     = ins;
    pc_i        = pc;
    flush_i     = fl;
    out_ready_i = ordy;
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic do_reset(input string tag);
    #2 rst_i = 1'b0;
    #1;
    check({tag, "_valid"},  BW'(out_valid_o), BW'(1'b0));
    check({tag, "_bundle"}, obs,              '0);
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    logic [4:0] rs1, rs2, rd;
    case ($urandom_range(0, 9))
      0: op = 7'b0110011;  1: op = 7'b0000011;  2: op = 7'b0100011;
      3: op = 7'b1100011;  4: op = 7'b0010011;  5: op = 7'b1101111;
      6: op = 7'b1100111;  7: op = 7'b0110111;  8: op = 7'b0010111;
      default: op = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    return {f7, rs2, rs1, 3'($urandom), rd, op};
  endfunction

  localparam logic [31:0] LW_X5  = 32'h0002A283;
  localparam logic [31:0] LW_X7  = 32'h0002A383;
  localparam logic [31:0] ADD_D  = 32'h00128333;

  initial begin
    model_reset();
    #2;
    check("reset_valid",  BW'(out_valid_o), BW'(1'b0));
    check("reset_bundle", obs,              '0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1 check("ready_after_reset", BW'(in_ready_o), BW'(1'b1));

    // Back-to-back R-type.
    drive(1'b1, 32'h00208033, 32'h100, 1'b0, 1'b1); tick();
    check("r0_valid",  BW'(out_valid_o), BW'(1'b1));
    check("r0_aluop",  BW'(ALUOp_o),     BW'(2'b10));
    drive(1'b1, 32'h40208033, 32'h104, 1'b0, 1'b1); tick();
    check("r1_valid",  BW'(out_valid_o), BW'(1'b1));
    check("r1_instr",  BW'(out_instr_o), BW'(32'h40208033));
    check("r1_regwr",  BW'({RegWrite_o, illegal_o}), BW'(2'b10));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();

    // Load-use: one bubble, then the add issues.
    drive(1'b1, LW_X5, 32'h200, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);   tick();
    drive(1'b1, ADD_D, 32'h204, 1'b0, 1'b1);
    #1 check("lu_stall_ready", BW'(in_ready_o), BW'(1'b0));
    tick();
    check("lu_bubble", BW'(out_valid_o), BW'(1'b0));
    #1 check("lu_release_ready", BW'(in_ready_o), BW'(1'b1));
    tick();
    check("lu_add_issued", BW'({out_valid_o, out_instr_o}), BW'({1'b1, ADD_D}));

    // Load to x7: the add of x5 does not stall.
    drive(1'b1, LW_X7, 32'h300, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);   tick();
    drive(1'b1, ADD_D, 32'h304, 1'b0, 1'b1);
    #1 check("nodep_ready", BW'(in_ready_o), BW'(1'b1));
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();

    // Backpressure: frozen for 3 cycles, next instruction taken on release.
    drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b0);
      #1 check("bp_ready", BW'(in_ready_o), BW'(1'b0));
      tick();
      check("bp_frozen", BW'({out_valid_o, out_instr_o}), BW'({1'b1, 32'h00100093}));
    end
    drive(1'b1, 32'h00200113, 32'h404, 1'b0, 1'b1);
    #1 check("bp_release_ready", BW'(in_ready_o), BW'(1'b1));
    tick();
    check("bp_next", BW'(out_instr_o), BW'(32'h00200113));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();

    // Flush during a stall removes the interlock.
    drive(1'b1, LW_X5, 32'h500, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);   tick();
    drive(1'b1, ADD_D, 32'h504, 1'b0, 1'b0);
    #1 check("fl_stall_ready", BW'(in_ready_o), BW'(1'b0));
    tick();
    drive(1'b1, ADD_D, 32'h504, 1'b1, 1'b0); tick();
    check("fl_valid", BW'(out_valid_o), BW'(1'b0));
    drive(1'b1, ADD_D, 32'h504, 1'b0, 1'b0);
    #1 check("fl_ready", BW'(in_ready_o), BW'(1'b1));
    tick();
    check("fl_add_valid", BW'(out_valid_o), BW'(1'b1));
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();

    // Illegal opcode, M extension, LUI.
    drive(1'b1, 32'h0000007F, 32'h600, 1'b0, 1'b1); tick();
    check("ill_flag", BW'({illegal_o, obs_ctrl}), BW'({1'b1, 12'h000}));
    drive(1'b1, 32'h02208033, 32'h604, 1'b0, 1'b1); tick();
    check("mul_mext",   BW'(illegal_o), BW'(1'b0));
    check("mul_nomext", BW'({n_illegal, n_reg_write}), BW'(2'b10));
    drive(1'b1, 32'h000122B7, 32'h608, 1'b0, 1'b1); tick();
    check("lui", BW'({UpperImm_o, ALUSrc_o, RegWrite_o}), BW'(4'b0111));

    // Reset with a valid bundle in the register.
    do_reset("rst_valid");
    // Reset mid-stall drops the interlock.
    drive(1'b1, LW_X5, 32'h700, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);   tick();
    drive(1'b1, ADD_D, 32'h704, 1'b0, 1'b1);
    #1 check("rst_stall_ready", BW'(in_ready_o), BW'(1'b0));
    do_reset("rst_stall");
    #1 check("rst_stall_cleared", BW'(in_ready_o), BW'(1'b1));
    tick();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
